intrapred_modesel: RTL and testbench
====================================

# intrapred_modesel

Parametrised, streaming intra-prediction mode-decision engine. It consumes per-mode prediction residues one block row per beat under valid/ready flow control, and accumulates a full-width SAD per mode. It then runs a sequential arg-min over the enabled modes and presents the winning mode and its SAD on a valid/ready output. It replaces the fixed-size SAD/decision stages of the intra pipeline with one block reusable for luma 4x4, luma 16x16 and chroma 8x8, with arbitrary mode count and per-block mode availability.

## Interface
- `BLK_W`, 4: block width in pixels, which is also the residues per mode per beat.
- `BLK_H`, 4: block height, which is also the number of beats per block.
- `NUM_MODES`, 9: number of candidate modes, minimum 2.
- `RES_W`, 9: signed residue width.
- Derived localparams:
  - `MODE_W = $clog2(NUM_MODES)`
  - `SAD_W = RES_W + $clog2(BLK_W*BLK_H)`
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a residue row is present.
- `in_ready` out 1: the block accepts a row.
- `in_res` in NUM_MODES\*BLK_W\*RES_W: residues. Mode m, column c sits at `[(m*BLK_W+c)*RES_W +: RES_W]`, two's complement.
- `in_mask` in NUM_MODES: bit m=1 means mode m is available. Sampled on the first row of a block only.
- `out_valid` out 1: decision available.
- `out_ready` in 1: consumer accepts the decision.
- `out_mode` out MODE_W: winning mode index.
- `out_sad` out SAD_W: unbiased SAD of the winning mode.
- `out_none` out 1: no mode was enabled.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, CMP, DONE.
- A beat is accepted when `in_valid && in_ready`. `in_ready` is 1 only in IDLE and ACCUM.
- IDLE, on accept:
  - Capture `in_mask`.
  - Load each mode's accumulator with the sum of |res| over that row.
  - Set row counter to 1.
  - If BLK_H==1, go to CMP; otherwise go to ACCUM.
- ACCUM, on accept:
  - Add the row sum to each accumulator and increment the row counter.
  - On the row with counter == BLK_H-1, go to CMP.
  - No other exit; idle cycles (`in_valid`=0) hold all state.
- Arithmetic: |x| is computed in RES_W unsigned, so |−2^(RES_W−1)| = 2^(RES_W−1) exactly. Accumulators are SAD_W wide and cannot overflow by construction.
- CMP: an index i runs from 0 to NUM_MODES−1, one mode per cycle.
  - Cost = accumulator (+ bias, see Configuration), with cost width SAD_W+1.
  - Mode i replaces the current best only if it is enabled AND (no best yet OR cost < best cost, strictly).
  - Ties therefore resolve to the lowest index. Masked modes still consume their cycle.
  - After i = NUM_MODES−1, go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_mode` and `out_sad` hold the best mode; `out_none`=1 if no mode was enabled, in which case `out_mode`=0 and `out_sad` = all ones.
  - Outputs are stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- Reset (any time, including mid-block): async clear to IDLE, which discards partial accumulation.
- Reset values:
  - `in_ready`=0 while `reset` is low, and 1 from the first cycle after release.
  - `out_valid`=0, `out_mode`=0, `out_sad`=0, `out_none`=0, `busy`=0.
  - Accumulators, mask and counters are 0.

## Timing
- Throughput is one row per cycle while `in_valid` is held.
- If the last row is accepted at edge k, CMP occupies edges k+1 … k+NUM_MODES. `out_valid` is high after edge k+NUM_MODES, so latency is NUM_MODES cycles.
- If the output is taken at edge j, `in_ready` is 1 after edge j. The next block's first row can be accepted at edge j+1.
- Minimum block period is BLK_H + NUM_MODES + 1 cycles.
- `in_ready` and `out_valid` are registered. `in_ready` never depends combinationally on `in_valid`; `out_valid` never depends combinationally on `out_ready`.
- `out_*` change only on the edge entering DONE or on reset.

## Configuration
- Macro: `INTRAPRED_MODESEL_BIAS_EN`.
- Defined:
  - Adds input `in_bias`, NUM_MODES\*8 bits, mode m at `[m*8 +: 8]`, unsigned.
  - `in_bias` is sampled with `in_mask` on the first row.
  - CMP cost = SAD + bias, used to approximate the mode-signalling rate.
  - `out_sad` still reports the unbiased SAD.
- Undefined: no `in_bias` port, and cost = SAD.

## Test plan
- Single block at defaults (4x4, 9 modes), all masks set:
  - Mode 3 residues are all 1, every other mode's are all 2.
  - Required: `out_mode`=3, `out_sad`=16, and `out_valid` rises exactly 9 cycles after the 4th accept.
- Tie handling: modes 2 and 5 both SAD 10, others larger → `out_mode`=2.
- Mask handling:
  - Mask 9'b000100000 with mode 5 the worst SAD → `out_mode`=5.
  - Mask 0 → `out_none`=1, `out_mode`=0, `out_sad` all ones.
- Extreme values and backpressure:
  - All residues −256 in mode 0 only enabled → `out_sad`=4096.
  - Holding `out_ready`=0 for 20 cycles keeps outputs stable and `in_ready`=0.
  - Back-to-back blocks then restart at edge j+1.
- Reset, with BLK_W=BLK_H=16, NUM_MODES=4, RES_W=9:
  - Pull `reset` low after 7 rows → IDLE immediately, `in_ready`=1 after release.
  - A fresh 16-row block then decides correctly, with no leftover sum.
- With `INTRAPRED_MODESEL_BIAS_EN` defined:
  - SADs {20, 18}, bias {0, 5} → `out_mode`=0, `out_sad`=20.
  - Bias all 0 → `out_mode`=1.

Source files
------------

// File: rtl/intrapred_modesel.sv
// Streaming intra-prediction mode decision: per-mode SAD accumulation over a block, then a sequential arg-min.
// Optional macro INTRAPRED_MODESEL_BIAS_EN adds a per-mode unsigned rate bias to the comparison cost.
module intrapred_modesel #(
  parameter  int BLK_W     = 4,
  parameter  int BLK_H     = 4,
  parameter  int NUM_MODES = 9,
  parameter  int RES_W     = 9,
  localparam int MODE_W    = $clog2(NUM_MODES),
  localparam int SAD_W     = RES_W + $clog2(BLK_W*BLK_H)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_MODES*BLK_W*RES_W-1:0] in_res,
  input  logic [NUM_MODES-1:0]             in_mask,
`ifdef INTRAPRED_MODESEL_BIAS_EN
  input  logic [NUM_MODES*8-1:0]           in_bias,
`endif
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MODE_W-1:0]                out_mode,
  output logic [SAD_W-1:0]                 out_sad,
  output logic                             out_none,
  output logic                             busy
);

  localparam int                ROW_W     = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(BLK_H - 1);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CMP, S_DONE} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_out_none;
  logic [MODE_W-1:0]   r_out_mode;
  logic [SAD_W-1:0]    r_out_sad;
  logic [SAD_W-1:0]    r_acc [NUM_MODES];
  logic [NUM_MODES-1:0] r_mask;
  logic [ROW_W-1:0]    r_row;
  logic [MODE_W-1:0]   r_idx;
  logic                r_have;
  logic [MODE_W-1:0]   r_best_mode;
  logic [SAD_W-1:0]    r_best_sad;
  logic [SAD_W:0]      r_best_cost;
`ifdef INTRAPRED_MODESEL_BIAS_EN
  logic [NUM_MODES*8-1:0] r_bias;
`endif

  logic [SAD_W-1:0]    w_row_sum [NUM_MODES];
  logic [SAD_W-1:0]    w_cur_sad;
  logic [SAD_W:0]      w_cur_cost;
  logic                w_take;
  logic                w_accept;

  // Magnitude kept in RES_W unsigned bits so the most negative residue maps exactly.
  function automatic logic [RES_W-1:0] abs_res(input logic [RES_W-1:0] x);
    return x[RES_W-1] ? -x : x;
  endfunction

  always_comb begin
    for (int unsigned m = 0; m < NUM_MODES; m++) begin
      w_row_sum[m] = '0;
      for (int unsigned c = 0; c < BLK_W; c++) begin
        w_row_sum[m] = w_row_sum[m] + SAD_W'(abs_res(in_res[(m*BLK_W+c)*RES_W +: RES_W]));
      end
    end
  end

  always_comb begin
    w_accept  = in_valid && r_in_ready;
    w_cur_sad = r_acc[r_idx];
`ifdef INTRAPRED_MODESEL_BIAS_EN
    w_cur_cost = {1'b0, w_cur_sad} + (SAD_W+1)'(r_bias[{r_idx, 3'b000} +: 8]);
`else
    w_cur_cost = {1'b0, w_cur_sad};
`endif
    w_take = r_mask[r_idx] && (!r_have || (w_cur_cost < r_best_cost));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_none  <= 1'b0;
      r_out_mode  <= '0;
      r_out_sad   <= '0;
      for (int unsigned m = 0; m < NUM_MODES; m++) r_acc[m] <= '0;
      r_mask      <= '0;
      r_row       <= '0;
      r_idx       <= '0;
      r_have      <= 1'b0;
      r_best_mode <= '0;
      r_best_sad  <= '0;
      r_best_cost <= '0;
`ifdef INTRAPRED_MODESEL_BIAS_EN
      r_bias      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_mask <= in_mask;
`ifdef INTRAPRED_MODESEL_BIAS_EN
            r_bias <= in_bias;
`endif
            for (int unsigned m = 0; m < NUM_MODES; m++) r_acc[m] <= w_row_sum[m];
            r_row  <= ROW_W'(1);
            r_idx  <= '0;
            r_have <= 1'b0;
            if (BLK_H == 1) begin
              r_state    <= S_CMP;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            for (int unsigned m = 0; m < NUM_MODES; m++) r_acc[m] <= r_acc[m] + w_row_sum[m];
            r_row <= r_row + 1'b1;
            if (r_row == LAST_ROW) begin
              r_state    <= S_CMP;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_CMP: begin
          if (w_take) begin
            r_have      <= 1'b1;
            r_best_mode <= r_idx;
            r_best_sad  <= w_cur_sad;
            r_best_cost <= w_cur_cost;
          end
          // The last mode's verdict is folded straight into the registered outputs.
          if (r_idx == LAST_MODE) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            if (w_take) begin
              r_out_mode <= r_idx;
              r_out_sad  <= w_cur_sad;
              r_out_none <= 1'b0;
            end else if (r_have) begin
              r_out_mode <= r_best_mode;
              r_out_sad  <= r_best_sad;
              r_out_none <= 1'b0;
            end else begin
              r_out_mode <= '0;
              r_out_sad  <= '1;
              r_out_none <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_mode  = r_out_mode;
  assign out_sad   = r_out_sad;
  assign out_none  = r_out_none;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_intrapred_modesel.sv
// Self-checking bench for intrapred_modesel: default 4x4/9-mode instance plus a 16x16/4-mode instance for reset.
module tb_intrapred_modesel;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: defaults ----------------
  logic         rst_a, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_none, a_busy;
  logic [323:0] a_in_res;
  logic [8:0]   a_in_mask;
  logic [3:0]   a_out_mode;
  logic [12:0]  a_out_sad;
`ifdef INTRAPRED_MODESEL_BIAS_EN
  logic [71:0]  a_in_bias;
  logic [31:0]  b_in_bias;
`endif

  intrapred_modesel u_dut_a (
    .clk(clk), .reset(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_res(a_in_res), .in_mask(a_in_mask),
`ifdef INTRAPRED_MODESEL_BIAS_EN
    .in_bias(a_in_bias),
`endif
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode),
    .out_sad(a_out_sad), .out_none(a_out_none), .busy(a_busy)
  );

  // ---------------- DUT B: 16x16, 4 modes ----------------
  logic         rst_b, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_none, b_busy;
  logic [575:0] b_in_res;
  logic [3:0]   b_in_mask;
  logic [1:0]   b_out_mode;
  logic [16:0]  b_out_sad;

  intrapred_modesel #(.BLK_W(16), .BLK_H(16), .NUM_MODES(4), .RES_W(9)) u_dut_b (
    .clk(clk), .reset(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_res(b_in_res), .in_mask(b_in_mask),
`ifdef INTRAPRED_MODESEL_BIAS_EN
    .in_bias(b_in_bias),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode),
    .out_sad(b_out_sad), .out_none(b_out_none), .busy(b_busy)
  );

  // ---------------- stimulus store and reference model ----------------
  int         stim [16][16][9];   // [row][col][mode], signed residues
  int         bias_s [9];
  logic [8:0] mask_s;
  int         exp_mode, exp_sad, exp_none;
  int         last_acc;

  function automatic void model(input int nm, input int bw, input int bh, input int sadw);
    int best, bcost, bsad;
    best = -1; bcost = 0; bsad = 0;
    for (int m = 0; m < nm; m++) begin
      if (mask_s[m]) begin
        int s, cost;
        s = 0;
        for (int r = 0; r < bh; r++)
          for (int c = 0; c < bw; c++)
            s += (stim[r][c][m] < 0) ? -stim[r][c][m] : stim[r][c][m];
        cost = s + bias_s[m];
        if (best < 0 || cost < bcost) begin
          best = m; bcost = cost; bsad = s;
        end
      end
    end
    exp_none = (best < 0) ? 1 : 0;
    exp_mode = (best < 0) ? 0 : best;
    exp_sad  = (best < 0) ? ((1 << sadw) - 1) : bsad;
  endfunction

  task automatic fill(input int m, input int v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) stim[r][c][m] = v;
  endtask

  task automatic rand_stim();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        for (int m = 0; m < 9; m++) stim[r][c][m] = int'($urandom_range(0, 511)) - 256;
  endtask

  // ---------------- DUT A drivers ----------------
  task automatic feed_a(input int gap_pct, output int first_acc);
    int n;
    first_acc = 0;
    for (int r = 0; r < 4; r++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        a_in_valid = 1'b0;
        a_in_res   = {11{$urandom}};
        @(negedge clk);
      end
      for (int m = 0; m < 9; m++)
        for (int c = 0; c < 4; c++) a_in_res[(m*4+c)*9 +: 9] = 9'(stim[r][c][m]);
      a_in_valid = 1'b1;
      // mask/bias are only meaningful on the first row; later rows carry garbage
      a_in_mask = (r == 0) ? mask_s : 9'($urandom);
`ifdef INTRAPRED_MODESEL_BIAS_EN
      for (int m = 0; m < 9; m++) a_in_bias[m*8 +: 8] = (r == 0) ? 8'(bias_s[m]) : 8'($urandom);
`endif
      n = 0;
      while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
      check("a_in_ready_wait", int'(n < 50), 1);
      if (r == 0) first_acc = cyc + 1;
      last_acc = cyc + 1;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_in_mask  = 9'($urandom);
  endtask

  task automatic finish_a(input int hold, output int take_edge);
    int n;
    n = 0;
    while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
    check("a_out_valid_wait", int'(a_out_valid), 1);
    check("a_latency", cyc - last_acc, 9);
    model(9, 4, 4, 13);
    check("a_mode", int'(a_out_mode), exp_mode);
    check("a_sad", int'(a_out_sad), exp_sad);
    check("a_none", int'(a_out_none), exp_none);
    check("a_in_ready_done", int'(a_in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("a_hold_valid", int'(a_out_valid), 1);
      check("a_hold_mode", int'(a_out_mode), exp_mode);
      check("a_hold_sad", int'(a_out_sad), exp_sad);
      check("a_hold_in_ready", int'(a_in_ready), 0);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    take_edge = cyc;
    check("a_take_in_ready", int'(a_in_ready), 1);
    check("a_take_out_valid", int'(a_out_valid), 0);
    check("a_take_busy", int'(a_busy), 0);
  endtask

  // ---------------- DUT B driver ----------------
  task automatic feed_b(input int nrows);
    int n;
    for (int r = 0; r < nrows; r++) begin
      for (int m = 0; m < 4; m++)
        for (int c = 0; c < 16; c++) b_in_res[(m*16+c)*9 +: 9] = 9'(stim[r][c][m]);
      b_in_valid = 1'b1;
      b_in_mask  = (r == 0) ? mask_s[3:0] : 4'($urandom);
      n = 0;
      while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
      check("b_in_ready_wait", int'(n < 50), 1);
      last_acc = cyc + 1;
      @(negedge clk);
    end
    b_in_valid = 1'b0;
  endtask

  int fa, tk;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    a_in_valid = 1'b0; a_in_res = '0; a_in_mask = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_res = '0; b_in_mask = '0; b_out_ready = 1'b0;
`ifdef INTRAPRED_MODESEL_BIAS_EN
    a_in_bias = '0; b_in_bias = '0;
`endif
    for (int m = 0; m < 9; m++) bias_s[m] = 0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", int'(a_in_ready), 0);
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_out_mode", int'(a_out_mode), 0);
    check("rst_out_sad", int'(a_out_sad), 0);
    check("rst_out_none", int'(a_out_none), 0);
    check("rst_busy", int'(a_busy), 0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    check("rel_in_ready", int'(a_in_ready), 1);

    // mode 3 cheapest
    mask_s = '1;
    for (int m = 0; m < 9; m++) fill(m, 2);
    fill(3, 1);
    feed_a(0, fa);
    finish_a(0, tk);
    check("t1_mode", int'(a_out_mode), 3);
    check("t1_sad", int'(a_out_sad), 16);

    // tie between modes 2 and 5 resolves to lower index
    for (int m = 0; m < 9; m++) fill(m, 3);
    fill(2, 0); fill(5, 0);
    for (int k = 0; k < 10; k++) begin
      stim[k/4][k%4][2] = (k % 2 == 0) ? 1 : -1;
      stim[k/4][k%4][5] = -1;
    end
    feed_a(0, fa);
    finish_a(0, tk);
    check("t2_tie_mode", int'(a_out_mode), 2);

    // single enabled mode wins even though it is worst
    mask_s = 9'b000100000;
    for (int m = 0; m < 9; m++) fill(m, 1);
    fill(5, -5);
    feed_a(0, fa);
    finish_a(0, tk);
    check("t3_mask_mode", int'(a_out_mode), 5);
    check("t3_mask_sad", int'(a_out_sad), 80);

    // nothing enabled
    mask_s = '0;
    rand_stim();
    feed_a(0, fa);
    finish_a(0, tk);
    check("t4_none", int'(a_out_none), 1);
    check("t4_none_mode", int'(a_out_mode), 0);
    check("t4_none_sad", int'(a_out_sad), 8191);

    // most negative residues, then output backpressure
    mask_s = 9'b000000001;
    rand_stim();
    fill(0, -256);
    feed_a(0, fa);
    finish_a(20, tk);
    check("t5_sad", int'(a_out_sad), 4096);

    // back-to-back: next first row accepted at take edge + 1
    mask_s = '1;
    rand_stim();
    feed_a(0, fa);
    check("t6_b2b_edge", fa, tk + 1);
    finish_a(0, tk);

    // randomized blocks with input gaps and random output stalls
    for (int it = 0; it < 25; it++) begin
      rand_stim();
      mask_s = (it % 8 == 7) ? 9'd0 : 9'($urandom);
`ifdef INTRAPRED_MODESEL_BIAS_EN
      for (int m = 0; m < 9; m++) bias_s[m] = int'($urandom_range(0, 255));
`endif
      feed_a(30, fa);
      finish_a(int'($urandom_range(0, 3)), tk);
    end
    for (int m = 0; m < 9; m++) bias_s[m] = 0;

`ifdef INTRAPRED_MODESEL_BIAS_EN
    // bias tips the decision; reported SAD stays unbiased
    mask_s = 9'b000000011;
    for (int m = 0; m < 9; m++) fill(m, 7);
    fill(0, 1); fill(1, 1);
    for (int k = 0; k < 4; k++) stim[0][k][0] = 2;
    for (int k = 0; k < 2; k++) stim[1][k][1] = -2;
    bias_s[1] = 5;
    feed_a(0, fa);
    finish_a(0, tk);
    check("bias_mode", int'(a_out_mode), 0);
    check("bias_sad", int'(a_out_sad), 20);
    bias_s[1] = 0;
    feed_a(0, fa);
    finish_a(0, tk);
    check("nobias_mode", int'(a_out_mode), 1);
    check("nobias_sad", int'(a_out_sad), 18);
`endif

    // DUT B: reset mid-block discards the partial sums
    mask_s = 9'h00F;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        for (int m = 0; m < 4; m++) stim[r][c][m] = (m == 0) ? 255 : 1;
    feed_b(7);
    rst_b = 1'b0;
    #1;
    check("b_rst_in_ready", int'(b_in_ready), 0);
    check("b_rst_busy", int'(b_busy), 0);
    check("b_rst_out_valid", int'(b_out_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_rel_in_ready", int'(b_in_ready), 1);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        for (int m = 0; m < 4; m++) stim[r][c][m] = (m == 0) ? 0 : ((m == 1) ? -3 : int'($urandom_range(4, 20)));
    feed_b(16);
    begin
      int n;
      n = 0;
      while (!b_out_valid && n < 100) begin @(negedge clk); n++; end
    end
    check("b_out_valid_wait", int'(b_out_valid), 1);
    check("b_latency", cyc - last_acc, 4);
    model(4, 16, 16, 17);
    check("b_mode", int'(b_out_mode), exp_mode);
    check("b_mode_direct", int'(b_out_mode), 0);
    check("b_sad", int'(b_out_sad), exp_sad);
    check("b_none", int'(b_out_none), exp_none);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_take_in_ready", int'(b_in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
